// File: rtl/jtag_bridge_pkg.sv
// Shared types and sizing helpers for the JTAG user-chain to memory bridge.
package jtag_bridge_pkg;

   // Command opcode carried in the two MSBs of the data register.
   typedef enum logic [1:0] {
      OP_NOP      = 2'b00,
      OP_SET_ADDR = 2'b01,
      OP_WRITE    = 2'b10,
      OP_READ     = 2'b11
   } op_e;

   // Memory-port access sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // Status bits at the top of a captured DR: {busy, err, ovf}.
   localparam int STATUS_BITS = 3;

   // DR length: status/opcode bits on top of the wider of address and data.
   function automatic int dr_width(input int aw, input int dw);
      return STATUS_BITS + ((aw > dw) ? aw : dw);
   endfunction

endpackage

// File: rtl/jtag_dr_shift.sv
// Capture/shift data register for the JTAG user chain; LSB leaves on tdo first.
module jtag_dr_shift #(
   parameter int DRW = 67
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sel,
   input  logic           capture,
   input  logic           shift,
   input  logic           tdi,
   input  logic [DRW-1:0] cap_data,
   output logic [DRW-1:0] sr,
   output logic           tdo
);

   // Capture beats shift; both are ignored unless the user instruction is selected.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (sel) begin
         if (capture) begin
            sr <= cap_data;
         end else if (shift) begin
            sr <= {tdi, sr[DRW-1:1]};
         end
      end
   end

   assign tdo = sr[0];

endmodule

// File: rtl/jtag_mem_bridge.sv
// JTAG user-chain to memory bridge, entirely in the TCK domain. A single command
// DR carries set-address / write / read; the access sequencer drives a req/gnt/rvalid
// port with optional auto-increment, a wait-state timeout and sticky err/ovf status.
//
// Memory handshake: req_o is held high with addr_o/we_o/wdata_o stable until gnt_i
// is seen on a rising edge. Writes finish on that edge; reads then wait for
// rvalid_i on a later edge (rvalid_i in the gnt_i cycle is ignored).
module jtag_mem_bridge
   import jtag_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int AUTO_INC   = 1,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  sel_i,
   input  logic                  capture_i,
   input  logic                  shift_i,
   input  logic                  update_i,
   input  logic                  tdi_i,
   output logic                  tdo_o,
   output logic                  req_o,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   input  logic                  gnt_i,
   input  logic                  rvalid_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic                  init_o,
   output logic                  busy_o,
   output logic [1:0]            state_dbg
);

   localparam int DRW = dr_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int CW  = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]         LAST_CNT = CW'(TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(DATA_WIDTH / 8);

   state_e                state, next_state;
   logic [DRW-1:0]        sr, cap_data;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [CW-1:0]         cnt_q;
   logic                  we_q, err_q, ovf_q, init_q;
   logic                  cap_fire, upd_fire, is_access, ctl;
   logic                  done, tout, load_rdata;
   op_e                   op;

   // Update only counts when no higher-priority strobe is active in the same cycle.
   assign cap_fire  = sel_i & capture_i;
   assign upd_fire  = sel_i & update_i & ~capture_i & ~shift_i;
   assign op        = op_e'(sr[DRW-1:DRW-2]);
   assign ctl       = sr[DRW-3];
   assign is_access = upd_fire & ((op == OP_WRITE) | (op == OP_READ));

   // Status on top, read data in the low bits, zero padding in between.
   always_comb begin
      cap_data                  = '0;
      cap_data[DATA_WIDTH-1:0]  = rdata_q;
      cap_data[DRW-1:DRW-3]     = {busy_o, err_q, ovf_q};
   end

   jtag_dr_shift #(.DRW(DRW)) u_dr (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .sel      (sel_i),
      .capture  (capture_i),
      .shift    (shift_i),
      .tdi      (tdi_i),
      .cap_data (cap_data),
      .sr       (sr),
      .tdo      (tdo_o)
   );

   // Sequencer state register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= ST_IDLE;
      else         state <= next_state;
   end

   // Next-state decode plus completion/timeout events for the datapath.
   always_comb begin
      next_state = state;
      done       = 1'b0;
      tout       = 1'b0;
      load_rdata = 1'b0;
      case (state)
         ST_IDLE: begin
            if (is_access) next_state = ST_REQ;
         end
         ST_REQ: begin
            if (gnt_i) begin
               if (we_q) begin
                  done       = 1'b1;
                  next_state = ST_IDLE;
               end else begin
                  next_state = ST_RESP;
               end
            end else if (cnt_q == LAST_CNT) begin
               tout       = 1'b1;
               next_state = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (rvalid_i) begin
               done       = 1'b1;
               load_rdata = 1'b1;
               next_state = ST_IDLE;
            end else if (cnt_q == LAST_CNT) begin
               tout       = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Wait-state counter spans the whole access (REQ and RESP together).
   always_ff @(posedge clk_i) begin
      if (!rst_ni)                      cnt_q <= '0;
      else if (next_state == ST_IDLE)   cnt_q <= '0;
      else if (state != ST_IDLE)        cnt_q <= cnt_q + 1'b1;
   end

   // Command decode, status flags and access datapath registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         init_q  <= 1'b1;
      end else begin
         // A new event on the capture edge must survive the capture-clear.
         if (cap_fire) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
         end
         if (tout) err_q <= 1'b1;
         if (upd_fire && (op != OP_NOP)) begin
            if (state != ST_IDLE) begin
               ovf_q <= 1'b1;
            end else begin
               case (op)
                  OP_SET_ADDR: begin
                     addr_q <= sr[ADDR_WIDTH-1:0];
                     if (ctl) init_q <= 1'b0;
                  end
                  OP_WRITE: begin
                     wdata_q <= sr[DATA_WIDTH-1:0];
                     we_q    <= 1'b1;
                  end
                  OP_READ:  we_q <= 1'b0;
                  default:  ;
               endcase
            end
         end
         if (load_rdata) rdata_q <= rdata_i;
         if (done && (AUTO_INC != 0)) addr_q <= addr_q + ADDR_INC;
      end
   end

   assign req_o     = (state == ST_REQ);
   assign we_o      = req_o & we_q;
   assign addr_o    = addr_q;
   assign wdata_o   = wdata_q;
   assign busy_o    = (state != ST_IDLE);
   assign init_o    = init_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Directed bench for jtag_mem_bridge (AW=32, DW=64, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling edge of TCK.
module tb_jtag_mem_bridge;

   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int DRW = 67;

   logic          clk, rst_n;
   logic          sel, capture, shift, update, tdi, tdo;
   logic          req, we, gnt, rvalid, init, busy;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata, rdata;
   logic [1:0]    state_dbg;

   int total = 0;
   int bad   = 0;
   logic [DRW-1:0] exp_q[$];

   jtag_mem_bridge #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .AUTO_INC   (1),
      .TIMEOUT    (8)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .sel_i     (sel),
      .capture_i (capture),
      .shift_i   (shift),
      .update_i  (update),
      .tdi_i     (tdi),
      .tdo_o     (tdo),
      .req_o     (req),
      .we_o      (we),
      .addr_o    (addr),
      .wdata_o   (wdata),
      .gnt_i     (gnt),
      .rvalid_i  (rvalid),
      .rdata_i   (rdata),
      .init_o    (init),
      .busy_o    (busy),
      .state_dbg (state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DRW-1:0] cmd(input logic [1:0] op, input logic ctl,
                                          input logic [63:0] d);
      return {op, ctl, d};
   endfunction

   // Driver tasks: all are entered and left on a falling edge with strobes low.
   task automatic do_shift(input logic [DRW-1:0] v);
      for (int i = 0; i < DRW; i++) begin
         tdi   = v[i];
         shift = 1'b1;
         @(negedge clk);
      end
      shift = 1'b0;
      tdi   = 1'b0;
   endtask

   task automatic do_update();
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   task automatic do_capture(output logic [DRW-1:0] got);
      capture = 1'b1;
      @(negedge clk);
      capture = 1'b0;
      shift   = 1'b1;
      tdi     = 1'b0;
      for (int i = 0; i < DRW; i++) begin
         got[i] = tdo;
         @(negedge clk);
      end
      shift = 1'b0;
   endtask

   // Capture one DR and score it against the oldest expected word.
   task automatic check_capture(input string name);
      logic [DRW-1:0] got, exp;
      do_capture(got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got status=%b data=%h, expected status=%b data=%h",
                  name, got[66:64], got[63:0], exp[66:64], exp[63:0]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (init !== 1'b1) begin bad++; $display("FAIL reset_init got=%b exp=1", init); end
      total++; if (req  !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", req); end
      total++; if (tdo  !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (we   !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
   endtask

   task automatic test_write();
      do_shift(cmd(2'b01, 1'b0, 64'h1000));
      do_update();
      total++; if (init !== 1'b1) begin bad++; $display("FAIL setaddr_init got=%b exp=1", init); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL setaddr_busy got=%b exp=0", busy); end
      gnt = 1'b1;
      do_shift(cmd(2'b10, 1'b0, 64'hDEADBEEF_CAFEF00D));
      // Update without sel must not start the access.
      sel = 1'b0;
      do_update();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL nosel_busy got=%b exp=0", busy); end
      sel = 1'b1;
      do_update();
      total++; if (req !== 1'b1) begin bad++; $display("FAIL wr_req got=%b exp=1", req); end
      total++; if (we !== 1'b1) begin bad++; $display("FAIL wr_we got=%b exp=1", we); end
      total++; if (addr !== 32'h1000) begin bad++; $display("FAIL wr_addr got=%h exp=00001000", addr); end
      total++; if (wdata !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL wr_data got=%h exp=deadbeefcafef00d", wdata); end
      @(negedge clk);
      total++; if (req !== 1'b0) begin bad++; $display("FAIL wr_req_drop got=%b exp=0", req); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b exp=0", busy); end
      gnt = 1'b0;
   endtask

   task automatic test_read();
      do_shift(cmd(2'b11, 1'b0, 64'h0));
      do_update();
      total++; if (req !== 1'b1) begin bad++; $display("FAIL rd_req got=%b exp=1", req); end
      total++; if (we !== 1'b0) begin bad++; $display("FAIL rd_we got=%b exp=0", we); end
      total++; if (addr !== 32'h1008) begin bad++; $display("FAIL rd_addr_inc got=%h exp=00001008", addr); end
      @(negedge clk);
      @(negedge clk);
      // Grant in the third request cycle, with a stray rvalid that must be ignored.
      gnt    = 1'b1;
      rvalid = 1'b1;
      rdata  = 64'hBAD0BAD0BAD0BAD0;
      @(negedge clk);
      gnt    = 1'b0;
      rvalid = 1'b0;
      total++; if (req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rd_resp_wait got req=%b busy=%b exp req=0 busy=1", req, busy); end
      @(negedge clk);
      @(negedge clk);
      rvalid = 1'b1;
      rdata  = 64'h0123456789ABCDEF;
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = '0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_end got=%b exp=0", busy); end
      exp_q.push_back({3'b000, 64'h0123456789ABCDEF});
      check_capture("rd_capture");
   endtask

   task automatic test_timeout();
      int n;
      gnt = 1'b0;
      do_shift(cmd(2'b10, 1'b0, 64'h1111));
      do_update();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (req) n++;
         @(negedge clk);
      end
      total++; if (n != 8) begin bad++; $display("FAIL tout_req_cycles got=%0d exp=8", n); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL tout_busy got=%b exp=0", busy); end
      exp_q.push_back({3'b010, 64'h0123456789ABCDEF});
      check_capture("tout_status");
      exp_q.push_back({3'b000, 64'h0123456789ABCDEF});
      check_capture("tout_cleared");
   endtask

   task automatic test_back_to_back();
      gnt = 1'b0;
      do_shift(cmd(2'b10, 1'b0, 64'h2222));
      do_update();
      total++; if (addr !== 32'h1010) begin bad++; $display("FAIL tout_no_inc got=%h exp=00001010", addr); end
      total++; if (wdata !== 64'h2222) begin bad++; $display("FAIL b2b_wdata got=%h exp=2222", wdata); end
      // Second write while the first is still waiting for a grant.
      do_update();
      total++; if (wdata !== 64'h2222) begin bad++; $display("FAIL b2b_wdata_hold got=%h exp=2222", wdata); end
      exp_q.push_back({3'b101, 64'h0123456789ABCDEF});
      check_capture("busy_ovf_status");
      // The stalled write times out during readout.
      exp_q.push_back({3'b010, 64'h0123456789ABCDEF});
      check_capture("busy_then_tout");
   endtask

   task automatic test_wrap();
      gnt = 1'b1;
      do_shift(cmd(2'b01, 1'b1, 64'hFFFF_FFF8));
      do_update();
      total++; if (init !== 1'b0) begin bad++; $display("FAIL init_clear got=%b exp=0", init); end
      do_shift(cmd(2'b10, 1'b0, 64'hA5));
      do_update();
      total++; if (req !== 1'b1 || addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_wr_addr got req=%b addr=%h exp req=1 addr=fffffff8", req, addr); end
      @(negedge clk);
      do_shift(cmd(2'b11, 1'b0, 64'h0));
      do_update();
      total++; if (req !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL wrap_rd_addr got req=%b addr=%h exp req=1 addr=00000000", req, addr); end
      @(negedge clk);
      rvalid = 1'b1;
      rdata  = 64'h77;
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = '0;
      exp_q.push_back({3'b000, 64'h77});
      check_capture("wrap_rd_capture");
      do_shift(cmd(2'b01, 1'b0, 64'h20));
      do_update();
      total++; if (init !== 1'b0) begin bad++; $display("FAIL init_sticky got=%b exp=0", init); end
      gnt = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      gnt = 1'b0;
      do_shift(cmd(2'b11, 1'b0, 64'h0));
      do_update();
      total++; if (req !== 1'b1) begin bad++; $display("FAIL rst_mid_req_pre got=%b exp=1", req); end
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_drop got req=%b busy=%b exp 0 0", req, busy); end
      total++; if (init !== 1'b1 || tdo !== 1'b0) begin bad++; $display("FAIL rst_mid_init got init=%b tdo=%b exp 1 0", init, tdo); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b1; capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_back_to_back();
      test_wrap();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
